fetch_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the single-issue 32-bit core. It owns the program counter, fetches each instruction from an instruction memory over a req/ack handshake, and holds the instruction in a register for the decoder. It gates the control unit's register-write enable to exactly one cycle per instruction, and stops permanently on a halt opcode. It replaces the free-running per-clock PC increment, so the datapath tolerates variable-latency instruction memory.

---
 rtl/fetch_sequencer.sv | 80 ++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over a req/ack handshake,
// latches the instruction for decode and gates register writes to the single EXEC cycle.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        writereg_in,
  output logic        regwrite,
  output logic [31:0] programcounter,
  output logic [31:0] retired,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e state;

  assign imem_addr = programcounter;
  // Only path that is not registered: the write strobe follows the control unit within EXEC.
  assign regwrite  = writereg_in & (state == StExec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= StIdle;
      programcounter <= RESET_PC;
      instr          <= 32'h0;
      retired        <= 32'h0;
      imem_req       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (run) begin
            state    <= StFetch;
            imem_req <= 1'b1;
          end
        end
        StFetch: begin
          // The request is held until acked regardless of run.
          if (imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            if (imem_rdata[31:26] == HALT_OPCODE) begin
              state  <= StHalt;
              halted <= 1'b1;
            end else begin
              state <= StExec;
            end
          end
        end
        StExec: begin
          programcounter <= programcounter + 32'd4;
          retired        <= retired + 32'd1;
          if (run) begin
            state    <= StFetch;
            imem_req <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StHalt: begin
          state <= StHalt;
        end
        default: begin
          state    <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer; the bench acts as instruction memory
// and predicts PC/retired/instr per instruction with plain arithmetic.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        writereg_in = 1'b0;
  logic        regwrite;
  logic [31:0] programcounter;
  logic [31:0] retired;
  logic        halted;

  logic        run2 = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic [31:0] instr2;
  logic        wr2 = 1'b0;
  logic        regwrite2;
  logic [31:0] pc2;
  logic [31:0] ret2;
  logic        halted2;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .writereg_in(writereg_in),
    .regwrite(regwrite), .programcounter(programcounter), .retired(retired), .halted(halted)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .run(run2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instr(instr2), .writereg_in(wr2),
    .regwrite(regwrite2), .programcounter(pc2), .retired(ret2), .halted(halted2)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", programcounter, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    #1;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    last_instr = 32'h0;
    chk_reset_state();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Called with the DUT in FETCH; acks after lat wait cycles.
  task automatic run_instr(input logic [31:0] word, input int lat, input logic wr,
                           input logic run_after);
    run = run_after;
    for (int i = 0; i < lat; i++) begin
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
      chk("instr_hold", instr, last_instr);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      tick();
    end
    chk("req_ack", 32'(imem_req), 32'd1);
    chk("addr_ack", imem_addr, exp_pc);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (word[31:26] == 6'h3F) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_instr", instr, word);
      run = 1'b1;
      writereg_in = 1'b1;
      #1;
      chk("halt_regwrite", 32'(regwrite), 32'd0);
      for (int i = 0; i < 20; i++) begin
        tick();
        chk("halt_noreq", 32'(imem_req), 32'd0);
        chk("halt_pc", programcounter, exp_pc);
        chk("halt_retired", retired, exp_ret);
      end
      writereg_in = 1'b0;
      return;
    end
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_instr", instr, word);
    chk("exec_pc", programcounter, exp_pc);
    writereg_in = wr;
    #1;
    chk("exec_regwrite", 32'(regwrite), 32'(wr));
    tick();
    writereg_in = 1'b1;
    #1;
    chk("post_regwrite", 32'(regwrite), 32'd0);
    writereg_in = 1'b0;
    exp_pc = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    last_instr = word;
    chk("next_pc", programcounter, exp_pc);
    chk("next_retired", retired, exp_ret);
    chk("next_req", 32'(imem_req), 32'(run_after));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  initial begin
    #12;
    do_reset();

    // PC wrap from the top of the address space
    run2 = 1'b1;
    tick();
    chk("wrap_req", 32'(req2), 32'd1);
    chk("wrap_addr", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1;
    rdata2 = 32'h0000_0013;
    run2 = 1'b0;
    tick();
    ack2 = 1'b0;
    tick();
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_retired", ret2, 32'd1);
    chk("wrap_req_idle", 32'(req2), 32'd0);

    // Zero-latency back-to-back, then 3-cycle latency
    run = 1'b1;
    tick();
    chk("start_req", 32'(imem_req), 32'd1);
    run_instr(32'h0000_0013, 0, 1'b1, 1'b1);
    run_instr(32'h0040_0093, 0, 1'b0, 1'b1);
    run_instr(32'h0080_0113, 0, 1'b1, 1'b1);
    chk("three_retired", retired, 32'd3);
    run_instr(32'h1234_5678, 3, 1'b1, 1'b1);
    run_instr(32'h0BAD_F00D, 3, 1'b1, 1'b1);

    // Reset mid-FETCH with a stray ack afterwards
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    run = 1'b0;
    #1;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    last_instr = 32'h0;
    chk_reset_state();
    tick();
    reset = 1'b1;
    tick();
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("stray_instr", instr, 32'h0);
    chk("stray_req", 32'(imem_req), 32'd0);
    tick();
    chk("stray_idle", 32'(imem_req), 32'd0);
    chk("stray_pc", programcounter, 32'h0);

    // run dropped during second FETCH, then resume and halt at 0x10
    run = 1'b1;
    tick();
    run_instr(32'h0000_0013, 0, 1'b1, 1'b1);
    run_instr(32'h0000_0033, 2, 1'b1, 1'b0);
    chk("drop_pc", programcounter, 32'h8);
    chk("drop_retired", retired, 32'd2);
    tick();
    chk("drop_idle_req", 32'(imem_req), 32'd0);
    run = 1'b1;
    tick();
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h8);
    run_instr(32'h0000_0073, 1, 1'b0, 1'b1);
    run_instr(32'h0000_00B3, 0, 1'b1, 1'b1);
    chk("halt_at_pc", imem_addr, 32'h10);
    run_instr(32'hFC00_0000, 1, 1'b1, 1'b1);

    // Randomized traffic against the arithmetic model
    do_reset();
    run = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      logic ra;
      ra = ($urandom_range(0, 3) != 0);
      run_instr(rand_word(), int'($urandom_range(0, 3)), 1'($urandom), ra);
      if (!ra) begin
        repeat (2) begin
          imem_ack = 1'($urandom);
          tick();
          chk("rnd_idle_req", 32'(imem_req), 32'd0);
          chk("rnd_idle_pc", programcounter, exp_pc);
        end
        imem_ack = 1'b0;
        run = 1'b1;
        tick();
      end
    end
    chk("rnd_final_retired", retired, 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
